// File: rtl/router_pkg.sv
// Shared router definitions: packet header layout, output directions, FSM
// state types and the XY route function.
// No ports (package).
package router_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned COORD_W    = 4;
  localparam int unsigned DEST_X_LSB = 28;
  localparam int unsigned DEST_Y_LSB = 24;
  localparam int unsigned NUM_DIRS   = 5;

  typedef logic [COORD_W-1:0] coord_t;

  // Output-port direction; the value is the bit index in a one-hot request.
  typedef enum logic [2:0] {
    DIR_L = 3'd0,
    DIR_E = 3'd1,
    DIR_W = 3'd2,
    DIR_N = 3'd3,
    DIR_S = 3'd4
  } dir_e;

  typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;
  typedef enum logic {TX_SEL, TX_REQ} tx_state_e;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [NUM_DIRS-1:0] xy_route(input coord_t dest_x, input coord_t dest_y,
                                                   input coord_t my_x, input coord_t my_y);
    dir_e dir;
    if (dest_x > my_x)      dir = DIR_E;
    else if (dest_x < my_x) dir = DIR_W;
    else if (dest_y > my_y) dir = DIR_N;
    else if (dest_y < my_y) dir = DIR_S;
    else                    dir = DIR_L;
    return NUM_DIRS'(1) << dir;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Single-clock packet FIFO with registered full/empty flags and a
// combinational head output.
// Ports: clk, rst (async, active-high), wr_en/wdata (push, ignored when full),
//        rd_en (pop, ignored when empty), rdata (head entry), full, empty.
module rx_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              do_wr;
  logic              do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rdata = mem[rd_ptr];

  // Simultaneous push and pop leave the occupancy unchanged.
  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)      count_nxt = count + CW'(1);
    else if (!do_wr && do_rd) count_nxt = count - CW'(1);
  end

  // Storage is not reset; flags guard every read of it.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/input_port_rx.sv
// Router input channel: accepts packets from the upstream req/gnt link into
// two buffers, XY-routes the head of the served buffer and requests the local
// output-port arbiters, popping on grant. Buffers are served alternately.
// Ports: clk, rst (async, active-high); reqUpStr/PacketIn/gntUpStr upstream
//        handshake; full1/full2 buffer-full flags; reqOut (one-hot
//        L,E,W,N,S), gntOut and PacketOut towards the output-port arbiters.
module input_port_rx #(
  parameter int unsigned DATA_W = router_pkg::DATA_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reqUpStr,
  input  logic [DATA_W-1:0]             PacketIn,
  output logic                          gntUpStr,
  output logic                          full1,
  output logic                          full2,
  output logic [router_pkg::NUM_DIRS-1:0] reqOut,
  input  logic [router_pkg::NUM_DIRS-1:0] gntOut,
  output logic [DATA_W-1:0]             PacketOut
);

  import router_pkg::*;

  rx_state_e         rx_state;
  tx_state_e         tx_state;
  logic              wr1;
  logic              wr2;
  logic              rd1;
  logic              rd2;
  logic              pop;
  logic              empty1;
  logic              empty2;
  logic [DATA_W-1:0] head1;
  logic [DATA_W-1:0] head2;
  logic [DATA_W-1:0] head_pick;
  logic              serve;       // 0 = buffer 1 has priority, 1 = buffer 2
  logic              sel;         // buffer currently being requested
  logic              pick;
  logic              pick_valid;

  // A write only happens in the idle state, so one request never writes twice.
  assign wr1 = (rx_state == RX_IDLE) && reqUpStr && !full1;
  assign wr2 = (rx_state == RX_IDLE) && reqUpStr && full1 && !full2;

  // Grant counts only on the bit actually requested.
  assign pop = (tx_state == TX_REQ) && (|(gntOut & reqOut));
  assign rd1 = pop && !sel;
  assign rd2 = pop && sel;

  // Prefer the served buffer, fall back to the other one.
  assign pick_valid = !(empty1 && empty2);
  assign pick       = (serve ? empty2 : empty1) ? ~serve : serve;
  assign head_pick  = pick ? head2 : head1;

  rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .wdata(PacketIn),
    .rd_en(rd1), .rdata(head1), .full(full1), .empty(empty1)
  );

  rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf2 (
    .clk(clk), .rst(rst), .wr_en(wr2), .wdata(PacketIn),
    .rd_en(rd2), .rdata(head2), .full(full2), .empty(empty2)
  );

  // Upstream write handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      gntUpStr <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          gntUpStr <= 1'b0;
          if (reqUpStr && !(full1 && full2)) begin
            gntUpStr <= 1'b1;
            rx_state <= RX_ACK;
          end
        end
        RX_ACK: begin
          gntUpStr <= 1'b0;
          if (!reqUpStr) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Downstream request/grant towards the output-port arbiters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_SEL;
      reqOut    <= '0;
      PacketOut <= '0;
      serve     <= 1'b0;
      sel       <= 1'b0;
    end else begin
      case (tx_state)
        TX_SEL: begin
          if (pick_valid) begin
            sel       <= pick;
            PacketOut <= head_pick;
            reqOut    <= xy_route(head_pick[DEST_X_LSB +: COORD_W],
                                  head_pick[DEST_Y_LSB +: COORD_W],
                                  COORD_W'(MY_X), COORD_W'(MY_Y));
            tx_state  <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (pop) begin
            reqOut   <= '0;
            serve    <= ~sel;
            tx_state <= TX_SEL;
          end
        end
        default: tx_state <= TX_SEL;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_rx.sv
// Self-checking bench for input_port_rx at MY=(1,1), DEPTH=4, using a queue
// model of the two buffers and the alternating service rule.
module tb_input_port_rx;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqUpStr;
  logic [31:0] PacketIn;
  logic        gntUpStr;
  logic        full1;
  logic        full2;
  logic [4:0]  reqOut;
  logic [4:0]  gntOut;
  logic [31:0] PacketOut;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  bit          serve_m;
  bit          sel_valid;
  bit          sel_buf;

  input_port_rx #(.DATA_W(32), .DEPTH(DEPTH), .MY_X(1), .MY_Y(1)) dut (
    .clk(clk), .rst(rst), .reqUpStr(reqUpStr), .PacketIn(PacketIn),
    .gntUpStr(gntUpStr), .full1(full1), .full2(full2),
    .reqOut(reqOut), .gntOut(gntOut), .PacketOut(PacketOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Direction from the routing rule, as a one-hot L,E,W,N,S vector.
  function automatic logic [4:0] exp_route(input logic [31:0] pkt);
    int dx = int'(pkt[31:28]);
    int dy = int'(pkt[27:24]);
    int idx;
    if (dx > 1)      idx = 1;
    else if (dx < 1) idx = 2;
    else if (dy > 1) idx = 3;
    else if (dy < 1) idx = 4;
    else             idx = 0;
    return 5'(1 << idx);
  endfunction

  task automatic model_select();
    if (!sel_valid && (q1.size() + q2.size() > 0)) begin
      if (serve_m == 1'b0) sel_buf = (q1.size() > 0) ? 1'b0 : 1'b1;
      else                 sel_buf = (q2.size() > 0) ? 1'b1 : 1'b0;
      sel_valid = 1'b1;
    end
  endtask

  task automatic model_push(input logic [31:0] pkt);
    if (q1.size() < DEPTH) q1.push_back(pkt);
    else                   q2.push_back(pkt);
    model_select();
  endtask

  task automatic model_clear();
    q1.delete();
    q2.delete();
    serve_m   = 1'b0;
    sel_valid = 1'b0;
  endtask

  // Send one packet; optionally keep reqUpStr high for extra cycles after gnt.
  task automatic send_pkt(input logic [31:0] pkt, input int hold);
    int n = 0;
    int g = 0;
    @(negedge clk);
    PacketIn = pkt;
    reqUpStr = 1'b1;
    while (gntUpStr !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_seen", 32'(gntUpStr), 32'd1);
    if (gntUpStr === 1'b1) model_push(pkt);
    repeat (hold) begin
      @(negedge clk);
      if (gntUpStr === 1'b1) g++;
    end
    reqUpStr = 1'b0;
    @(negedge clk);
    chk("gnt_pulse_low", 32'(gntUpStr), 32'd0);
    if (hold > 0) chk("no_second_gnt", 32'(g), 32'd0);
    @(negedge clk);
    chk("full1", 32'(full1), 32'(q1.size() == DEPTH));
    chk("full2", 32'(full2), 32'(q2.size() == DEPTH));
  endtask

  // Wait for a request, check it against the model, grant it.
  task automatic service(input bit wrong_first);
    int n = 0;
    logic [31:0] exp;
    while (reqOut === 5'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(|reqOut), 32'd1);
    chk("model_has_pkt", 32'(sel_valid), 32'd1);
    if (sel_valid && (|reqOut)) begin
      exp = sel_buf ? q2[0] : q1[0];
      chk("reqOut_route", 32'(reqOut), 32'(exp_route(exp)));
      chk("PacketOut", PacketOut, exp);
      if (wrong_first) begin
        gntOut = ~reqOut;
        @(negedge clk);
        gntOut = 5'd0;
        chk("wrong_gnt_ignored", 32'(reqOut), 32'(exp_route(exp)));
      end
      gntOut = reqOut;
      @(negedge clk);
      gntOut = 5'd0;
      chk("req_drop_after_gnt", 32'(reqOut), 32'd0);
      if (sel_buf) void'(q2.pop_front());
      else         void'(q1.pop_front());
      serve_m   = ~sel_buf;
      sel_valid = 1'b0;
      model_select();
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q1.size() + q2.size() > 0 && k < 4 * DEPTH) begin
      service(k[0]);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("drain_req_idle", 32'(reqOut), 32'd0);
    chk("drain_full1", 32'(full1), 32'd0);
    chk("drain_full2", 32'(full2), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] dests[4];
    int n;
    int g;

    rst      = 1'b1;
    reqUpStr = 1'b0;
    PacketIn = 32'd0;
    gntOut   = 5'd0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gntUpStr), 32'd0);
    chk("rst_req", 32'(reqOut), 32'd0);
    chk("rst_pkt", PacketOut, 32'd0);
    chk("rst_full1", 32'(full1), 32'd0);
    chk("rst_full2", 32'(full2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single east-bound packet.
    send_pkt(32'h2100_00AA, 0);
    chk("t1_reqOut", 32'(reqOut), 32'h02);
    chk("t1_PacketOut", PacketOut, 32'h2100_00AA);
    service(1'b0);
    repeat (3) @(negedge clk);
    chk("t1_idle_after", 32'(reqOut), 32'd0);

    // Local, west, north, south.
    dests[0] = 32'h1100_0001;
    dests[1] = 32'h0100_0002;
    dests[2] = 32'h1200_0003;
    dests[3] = 32'h1000_0004;
    for (int i = 0; i < 4; i++) begin
      send_pkt(dests[i], 0);
      chk("t3_dir", 32'(reqOut), 32'(5'(1) << (i == 0 ? 0 : i + 1)));
      service(1'b0);
    end

    // Alternating service with both buffers occupied.
    for (int i = 0; i < DEPTH + 2; i++) send_pkt(32'h3300_0100 + 32'(i), 0);
    drain();

    // Fill both buffers; an extra request must wait for a grant.
    for (int i = 0; i < 2 * DEPTH; i++) send_pkt($urandom, 0);
    chk("t2_full1", 32'(full1), 32'd1);
    chk("t2_full2", 32'(full2), 32'd1);
    held = 32'hA5A5_5A5A;
    @(negedge clk);
    PacketIn = held;
    reqUpStr = 1'b1;
    g = 0;
    repeat (20) begin
      @(negedge clk);
      if (gntUpStr === 1'b1) g++;
    end
    chk("t2_no_gnt_when_full", 32'(g), 32'd0);
    service(1'b0);
    n = 0;
    while (gntUpStr !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t2_gnt_after_pop", 32'(gntUpStr), 32'd1);
    if (gntUpStr === 1'b1) model_push(held);
    reqUpStr = 1'b0;
    @(negedge clk);
    chk("t2_gnt_pulse_low", 32'(gntUpStr), 32'd0);
    drain();

    // Request held long after the grant writes only once.
    send_pkt(32'h0000_0077, 5);
    send_pkt(32'h2200_0078, 0);
    drain();

    // Reset while mid-handshake and mid-request.
    for (int i = 0; i < DEPTH; i++) send_pkt(32'h1300_0200 + 32'(i), 0);
    @(negedge clk);
    PacketIn = 32'h0000_0999;
    reqUpStr = 1'b1;
    n = 0;
    while (gntUpStr !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t6_gnt_seen", 32'(gntUpStr), 32'd1);
    @(negedge clk);
    chk("t6_pre_full1", 32'(full1), 32'd1);
    chk("t6_pre_req", 32'(reqOut), 32'(exp_route(q1[0])));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gntUpStr), 32'd0);
    chk("t6_rst_req", 32'(reqOut), 32'd0);
    chk("t6_rst_pkt", PacketOut, 32'd0);
    chk("t6_rst_full1", 32'(full1), 32'd0);
    chk("t6_rst_full2", 32'(full2), 32'd0);
    reqUpStr = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_discarded", 32'(reqOut), 32'd0);

    // Random mix of sends and grants against the queue model.
    for (int i = 0; i < 80; i++) begin
      if ((q1.size() + q2.size() == 0) ||
          ($urandom_range(0, 1) == 1 && q1.size() + q2.size() < 2 * DEPTH))
        send_pkt($urandom, int'($urandom_range(0, 2)));
      else
        service(1'($urandom_range(0, 1)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
